// File: rtl/mission_level_sequencer_pkg.sv
// Shared types and default constants for the
// mission level sequencer.
package mission_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_SET,
    S_L1_EVAL,
    S_L2_SET,
    S_L2_EVAL,
    S_L3_SET,
    S_L3_EVAL,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    OUT_NONE    = 2'b00,
    OUT_SUCCESS = 2'b01,
    OUT_ABORTED = 2'b10,
    OUT_FAILED  = 2'b11
  } outcome_t;

  localparam logic [4:0] DEF_E_L1 = 5'b11110;
  localparam logic [4:0] DEF_E_L2 = 5'b11100;
  localparam logic [4:0] DEF_E_L3 = 5'b11000;
  localparam logic [4:0] DEF_PERMIT_L2 = 5'b00010;
  localparam logic [4:0] DEF_PERMIT_L3 = 5'b00110;

endpackage

// File: rtl/mission_level_sequencer_if.sv
// Mission control bus: start/health in,
// masks, switches and outcome out.
interface mission_level_sequencer_if;
  logic       start;
  logic [4:0] r;
  logic [4:0] usr_off;
  logic [4:0] e_mask;
  logic       switch1_l2;
  logic       switch1_l3;
  logic [1:0] level;
  logic [4:0] o;
  logic [2:0] level_passed;
  logic       done;
  logic [1:0] outcome;

  modport master (
    output start, r, usr_off,
    input  e_mask, switch1_l2, switch1_l3,
    input  level, o, level_passed,
    input  done, outcome
  );

  modport slave (
    input  start, r, usr_off,
    output e_mask, switch1_l2, switch1_l3,
    output level, o, level_passed,
    output done, outcome
  );
endinterface

// File: rtl/mission_level_sequencer_level_eval.sv
// Per-level pass check and shut-off register
// update; mask and permit are muxed in by level.
module level_eval (
  input  logic [4:0] i_r,
  input  logic [4:0] i_mask,
  input  logic [4:0] i_permit,
  input  logic [4:0] i_usr_off,
  input  logic [4:0] i_off,
  output logic       o_pass,
  output logic [4:0] o_off_next
);

  // Pass uses raw health so shut-off never hides a fault.
  always_comb begin
    o_pass     = (i_r & i_mask) == i_mask;
    o_off_next = i_off;
    if (o_pass)
      o_off_next = i_off | (i_usr_off & i_permit);
  end

endmodule

// File: rtl/mission_level_sequencer.sv
// Level 1->2->3 mission sequencer with settle
// timing, bounded retry and a single outcome.
module mission_level_sequencer
  import mission_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         MAX_RETRY     = 1,
  parameter logic [4:0] E_L1      = DEF_E_L1,
  parameter logic [4:0] E_L2      = DEF_E_L2,
  parameter logic [4:0] E_L3      = DEF_E_L3,
  parameter logic [4:0] PERMIT_L2 = DEF_PERMIT_L2,
  parameter logic [4:0] PERMIT_L3 = DEF_PERMIT_L3
) (
  input logic                      clk,
  input logic                      rst,
  mission_level_sequencer_if.slave bus
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [RW-1:0] r_retry, w_retry;
  logic [4:0]    r_off, w_off;
  logic [4:0]    r_e_mask, w_e_mask;
  logic          r_sw2, w_sw2;
  logic          r_sw3, w_sw3;
  logic [1:0]    r_level, w_level;
  logic [4:0]    r_o, w_o;
  logic [2:0]    r_lp, w_lp;
  logic          r_done, w_done;
  logic [1:0]    r_outcome, w_outcome;

  logic [4:0] w_sel_mask;
  logic [4:0] w_sel_permit;
  logic       w_pass;
  logic [4:0] w_off_next;

  // Select the active level's mask and permit set.
  always_comb begin
    w_sel_mask   = E_L1;
    w_sel_permit = 5'b00000;
    unique case (r_level)
      2'd2: begin
        w_sel_mask   = E_L2;
        w_sel_permit = PERMIT_L2;
      end
      2'd3: begin
        w_sel_mask   = E_L3;
        w_sel_permit = PERMIT_L3;
      end
      default: ;
    endcase
  end

  level_eval u_eval (
    .i_r        (bus.r),
    .i_mask     (w_sel_mask),
    .i_permit   (w_sel_permit),
    .i_usr_off  (bus.usr_off),
    .i_off      (r_off),
    .o_pass     (w_pass),
    .o_off_next (w_off_next)
  );

  // Next-state and next-register computation.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_retry   = r_retry;
    w_off     = r_off;
    w_e_mask  = r_e_mask;
    w_sw2     = r_sw2;
    w_sw3     = r_sw3;
    w_level   = r_level;
    w_o       = r_o;
    w_lp      = r_lp;
    w_done    = 1'b0;
    w_outcome = r_outcome;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state   = S_L1_SET;
          w_cnt     = CNT_LOAD;
          w_off     = 5'b00000;
          w_lp      = 3'b000;
          w_outcome = OUT_NONE;
          w_retry   = '0;
          w_level   = 2'd1;
          w_e_mask  = E_L1;
        end
      end
      S_L1_SET, S_L2_SET, S_L3_SET: begin
        if (r_cnt == '0)
          w_state = state_t'(r_state + 3'd1);
        else
          w_cnt = r_cnt - CW'(1);
      end
      S_L1_EVAL, S_L2_EVAL, S_L3_EVAL: begin
        w_o   = bus.r & ~w_off_next;
        w_off = w_off_next;
        if (w_pass) begin
          w_retry = '0;
          unique case (r_state)
            S_L1_EVAL: begin
              w_lp[0]  = 1'b1;
              w_state  = S_L2_SET;
              w_cnt    = CNT_LOAD;
              w_e_mask = E_L2;
              w_sw2    = 1'b1;
              w_level  = 2'd2;
            end
            S_L2_EVAL: begin
              w_lp[1]  = 1'b1;
              w_state  = S_L3_SET;
              w_cnt    = CNT_LOAD;
              w_e_mask = E_L3;
              w_sw3    = 1'b1;
              w_level  = 2'd3;
            end
            default: begin
              w_lp[2]   = 1'b1;
              w_state   = S_FINISH;
              w_outcome = OUT_SUCCESS;
            end
          endcase
        end else if (r_retry < RMAX) begin
          w_retry = r_retry + RW'(1);
          w_state = state_t'(r_state - 3'd1);
          w_cnt   = CNT_LOAD;
        end else begin
          w_state   = S_FINISH;
          w_outcome = (r_state == S_L3_EVAL) ?
                      OUT_FAILED : OUT_ABORTED;
        end
        if (w_state == S_FINISH) begin
          w_done   = 1'b1;
          w_level  = 2'd0;
          w_sw2    = 1'b0;
          w_sw3    = 1'b0;
          w_e_mask = E_L1;
        end
      end
      S_FINISH: w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase
  end

  // State and datapath registers, async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_off     <= 5'b00000;
      r_e_mask  <= E_L1;
      r_sw2     <= 1'b0;
      r_sw3     <= 1'b0;
      r_level   <= 2'd0;
      r_o       <= 5'b00000;
      r_lp      <= 3'b000;
      r_done    <= 1'b0;
      r_outcome <= OUT_NONE;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_retry   <= w_retry;
      r_off     <= w_off;
      r_e_mask  <= w_e_mask;
      r_sw2     <= w_sw2;
      r_sw3     <= w_sw3;
      r_level   <= w_level;
      r_o       <= w_o;
      r_lp      <= w_lp;
      r_done    <= w_done;
      r_outcome <= w_outcome;
    end
  end

  assign bus.e_mask       = r_e_mask;
  assign bus.switch1_l2   = r_sw2;
  assign bus.switch1_l3   = r_sw3;
  assign bus.level        = r_level;
  assign bus.o            = r_o;
  assign bus.level_passed = r_lp;
  assign bus.done         = r_done;
  assign bus.outcome      = r_outcome;

endmodule

// File: tb/tb_mission_level_sequencer.sv
// Directed bench for the mission sequencer:
// nominal, abort, shut-off, fail, retry, reset.
module tb_mission_level_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mission_level_sequencer_if bus ();

  mission_level_sequencer #(
    .SETTLE_CYCLES (2),
    .MAX_RETRY     (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  int lat;
  bit saw_sw;
  bit cum_ok;

  // Start a mission; r switches to rb at cycle sw_cyc.
  task automatic run(input logic [4:0] ra,
                     input logic [4:0] rb,
                     input int sw_cyc,
                     input logic [4:0] uo);
    @(negedge clk);
    bus.r = ra;
    bus.usr_off = uo;
    bus.start = 1'b1;
    lat = 0;
    saw_sw = 1'b0;
    cum_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (lat == sw_cyc) bus.r = rb;
      if (bus.switch1_l2 || bus.switch1_l3)
        saw_sw = 1'b1;
      if (bus.level == 2'd3 && !bus.switch1_l2)
        cum_ok = 1'b0;
      if (bus.done) break;
    end
    check("done_seen", 32'(bus.done), 1);
  endtask

  // Check the outcome and the idle state after done.
  task automatic post(input string t,
                      input int lat_e,
                      input logic [1:0] out_e,
                      input logic [2:0] lp_e,
                      input logic [4:0] o_e,
                      input bit sw_e);
    check({t, "_lat"}, lat, lat_e);
    check({t, "_outcome"}, 32'(bus.outcome), 32'(out_e));
    check({t, "_lp"}, 32'(bus.level_passed), 32'(lp_e));
    check({t, "_o"}, 32'(bus.o), 32'(o_e));
    check({t, "_sw_seen"}, 32'(saw_sw), 32'(sw_e));
    check({t, "_sw_cum"}, 32'(cum_ok), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({t, "_done_1cyc"}, 32'(bus.done), 0);
    check({t, "_lvl_idle"}, 32'(bus.level), 0);
    check({t, "_sw_drop"},
          32'({bus.switch1_l2, bus.switch1_l3}), 0);
    check({t, "_mask_idle"}, 32'(bus.e_mask), 'h1e);
    repeat (2) @(negedge clk);
    check({t, "_start_ign"}, 32'(bus.level), 0);
    check({t, "_out_hold"}, 32'(bus.outcome), 32'(out_e));
  endtask

  bit done_in_rst;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.r = 5'b00000;
    bus.usr_off = 5'b00000;
    #12;
    check("rst_mask", 32'(bus.e_mask), 'h1e);
    check("rst_level", 32'(bus.level), 0);
    check("rst_sw",
          32'({bus.switch1_l2, bus.switch1_l3}), 0);
    check("rst_o", 32'(bus.o), 0);
    check("rst_lp", 32'(bus.level_passed), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_outcome", 32'(bus.outcome), 0);
    @(negedge clk);
    rst = 1'b0;

    run(5'b11111, 5'b11111, 0, 5'b00000);
    post("nominal", 10, 2'b01, 3'b111, 5'b11111, 1);

    run(5'b11101, 5'b11101, 0, 5'b00000);
    post("abort_l1", 7, 2'b10, 3'b000, 5'b11101, 0);

    run(5'b11111, 5'b11111, 0, 5'b00110);
    post("shutoff", 10, 2'b01, 3'b111, 5'b11001, 1);

    run(5'b11111, 5'b10111, 7, 5'b00000);
    post("fail_l3", 13, 2'b11, 3'b011, 5'b10111, 1);

    run(5'b11100, 5'b11110, 4, 5'b00000);
    post("retry_l1", 13, 2'b01, 3'b111, 5'b11110, 1);

    @(negedge clk);
    bus.r = 5'b11111;
    bus.usr_off = 5'b00000;
    bus.start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_level", 32'(bus.level), 2);
    check("mid_lp", 32'(bus.level_passed), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_level", 32'(bus.level), 0);
    check("arst_mask", 32'(bus.e_mask), 'h1e);
    check("arst_sw",
          32'({bus.switch1_l2, bus.switch1_l3}), 0);
    check("arst_lp", 32'(bus.level_passed), 0);
    check("arst_o", 32'(bus.o), 0);
    check("arst_outcome", 32'(bus.outcome), 0);
    done_in_rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) done_in_rst = 1'b1;
    end
    check("arst_no_done", 32'(done_in_rst), 0);
    rst = 1'b0;

    run(5'b11111, 5'b11111, 0, 5'b00000);
    post("after_rst", 10, 2'b01, 3'b111, 5'b11111, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mission_level_sequencer.md
Name: mission_level_sequencer

Overview:
- Hardware controller for the spacecraft fault-tolerance chain. It drives the level progression that the gate_level1/2/3 blocks are checked against.
- Consumes the 5-bit subsystem health word R1..R5 and steps Level 1 -> 2 -> 3 with enable masks 11110 / 11100 / 11000.
- Asserts the level switches and evaluates each level's pass condition, with bounded retry.
- Applies user shut-off requests and reports a single mission outcome with a done pulse.

Parameters:
- SETTLE_CYCLES, 2, clocks held in each SETTLE state before r is sampled (min 1)
- MAX_RETRY, 1, re-evaluations allowed per level after a failure before the outcome is final (0 = no retry)
- E_L1, 5'b11110, Level 1 enable mask
- E_L2, 5'b11100, Level 2 enable mask
- E_L3, 5'b11000, Level 3 enable mask
- PERMIT_L2, 5'b00010, bits the user may switch off at Level 2 (R4)
- PERMIT_L3, 5'b00110, bits the user may switch off at Level 3 (R3, R4)

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-high
- start, in, 1, single-cycle pulse that begins a mission; ignored unless in IDLE
- r, in, 5, subsystem health; r[4]=R1 ... r[0]=R5
- usr_off, in, 5, user shut-off request, sampled only in EVAL states
- e_mask, out, 5, active enable mask (E1=bit4)
- switch1_l2, out, 1, Level 2 switch
- switch1_l3, out, 1, Level 3 switch
- level, out, 2, current level: 0 idle/done, 1, 2, 3
- o, out, 5, sampled health masked by the cumulative shut-off register
- level_passed, out, 3, sticky per-level pass flags {L3,L2,L1}
- done, out, 1, one-cycle pulse when an outcome is written
- outcome, out, 2, 00 none, 01 SUCCESS, 10 ABORTED, 11 FAILED

Behaviour:
- Reset (async): state IDLE; e_mask=E_L1; switches=0; level=0; o=0; level_passed=0; done=0; outcome=00; settle counter, retry counter and off register cleared.
- States: IDLE, L1_SETTLE, L1_EVAL, L2_SETTLE, L2_EVAL, L3_SETTLE, L3_EVAL, FINISH.
- IDLE + start:
  - clear off register, level_passed, outcome and retry counter;
  - set level=1, e_mask=E_L1, enter L1_SETTLE.
- Lk_SETTLE:
  - counter loads SETTLE_CYCLES-1 on entry and counts down;
  - on 0, go to Lk_EVAL. Residency is exactly SETTLE_CYCLES cycles.
- Lk_EVAL (one cycle):
  - r is registered into o as r & ~off_next;
  - pass = ((r & e_mask) == e_mask), evaluated on raw r before shut-off.
- Pass at Lk:
  - set level_passed[k-1];
  - off_next = off | (usr_off & PERMIT_Lk); L1 permits nothing;
  - reset retry counter;
  - advance to the next level: e_mask <= E_L(k+1), switch1_l(k+1) <= 1, level <= k+1.
  - L3 pass goes to FINISH with outcome 01.
- Fail at Lk with retry < MAX_RETRY: retry++, re-enter Lk_SETTLE; mask and switches unchanged.
- Fail with retries exhausted: go to FINISH. L1 or L2 gives 10 (ABORTED); L3 gives 11 (FAILED).
- FINISH:
  - done=1 for exactly one cycle;
  - switches drop to 0, e_mask returns to E_L1, level=0;
  - outcome, o and level_passed hold until the next start;
  - next state IDLE.
- start outside IDLE is ignored, including start in the same cycle as the FINISH->IDLE transition.
- rst mid-mission aborts immediately to reset values. No outcome and no done pulse are produced.
- The off register is monotonic within a mission; shut-off never un-fails a level, because pass is checked on raw r.
- Switches are cumulative: switch1_l2 stays high during Level 3.

Decomposition:
- Package mission_pkg:
  - state enum;
  - outcome codes OUT_NONE/SUCCESS/ABORTED/FAILED;
  - default mask and permit constants.
- One sub-module, level_eval: combinational pass check plus off-register update, parameterised by mask and permit, instanced once and muxed by level.

Test Plan:
- r=11111 held, usr_off=0, start -> pass at L1/L2/L3; outcome=01; level_passed=111; o=11111; done pulses once; total latency 3*(SETTLE_CYCLES+1)+1 cycles from start.
- r=11101 (R4 bad), MAX_RETRY=1 -> L1 fails twice (two L1_SETTLE passes); outcome=10; level_passed=000; switches never asserted.
- r=11111, usr_off=00110 constant -> L2 takes bit1 only (off=00010) and L3 adds bit2 (off=00110); final o=11001; outcome=01.
- r=11111 until L3_SETTLE, then r=10111 -> L3 fails after the retry; outcome=11; level_passed=011.
- L1 fails once on r=11100, r is corrected to 11110 before the retry -> L1 passes, the retry counter resets, and the mission completes with outcome 01.
- rst asserted during L2_SETTLE -> all outputs take reset values asynchronously; no done; a later start runs cleanly from L1.
